// File: rtl/access_arbiter.sv
// access_arbiter: round-robin arbitration of NUM_REQ door terminals onto one key-parity checker.
// Define ACCESS_ARB_LOCKOUT_EN to enable per-terminal lockout after MAX_FAIL consecutive denials.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for an eligible request, capture index and key
// CHECK | evaluate latched key, update fail/lock state, advance rr_ptr
// RESP  | one-cycle ack/granted pulse to the served terminal
// WAIT  | hold until the served terminal drops req
module access_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int KEY_W       = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*KEY_W-1:0]     key_bus,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         granted,
    output logic [$clog2(NUM_REQ)-1:0]   served_id,
    output logic                         busy,
    output logic [NUM_REQ-1:0]           locked
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    logic [1:0]         state;
    logic [IDW-1:0]     rr_ptr;
    logic [KEY_W-1:0]   key_q;
    logic               result_q;
    logic [NUM_REQ-1:0] eligible;
    logic               pick_vld;
    logic [IDW-1:0]     pick_idx;
    logic [KEY_W-1:0]   pick_key;
    logic               key_pass;

    assign eligible = req & ~locked;
    assign key_pass = (key_q != '0) && !(^key_q);
    assign busy     = (state != IDLE);

    // First eligible terminal after rr_ptr, wrapping around.
    always_comb begin
        int cand;
        cand     = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_key = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_vld && eligible[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDW-1:0];
                pick_key = key_bus[cand*KEY_W +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            served_id <= '0;
            key_q     <= '0;
            result_q  <= 1'b0;
            rr_ptr    <= IDW'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        served_id <= pick_idx;
                        key_q     <= pick_key;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    result_q <= key_pass;
                    rr_ptr   <= served_id;
                    state    <= RESP;
                end
                RESP: state <= WAIT;
                WAIT: begin
                    if (!req[served_id]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (state == RESP) ack[served_id] = 1'b1;
    end

    assign granted = (state == RESP) && result_q;

`ifdef ACCESS_ARB_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCK_CYCLES + 1);

    logic [FW-1:0] fail_cnt [NUM_REQ];
    logic [TW-1:0] lock_tmr [NUM_REQ];

    // Lock timers are free-running; a locked terminal cannot be in CHECK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                fail_cnt[i] <= '0;
                lock_tmr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (locked[i]) begin
                    if (lock_tmr[i] == TW'(1)) begin
                        locked[i]   <= 1'b0;
                        lock_tmr[i] <= '0;
                        fail_cnt[i] <= '0;
                    end else begin
                        lock_tmr[i] <= lock_tmr[i] - 1'b1;
                    end
                end else if (state == CHECK && served_id == IDW'(i)) begin
                    if (key_pass) begin
                        fail_cnt[i] <= '0;
                    end else if (fail_cnt[i] == FW'(MAX_FAIL - 1)) begin
                        fail_cnt[i] <= FW'(MAX_FAIL);
                        locked[i]   <= 1'b1;
                        lock_tmr[i] <= TW'(LOCK_CYCLES);
                    end else if (fail_cnt[i] < FW'(MAX_FAIL)) begin
                        fail_cnt[i] <= fail_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign locked = '0;
`endif

endmodule
